// File: rtl/iq_integrate_dump_pkg.sv
// Shared types and helpers for the I/Q integrate-and-dump correlator.
package iq_pkg;

  localparam int ACC_MAX = 128;
  localparam int OUT_MAX = 64;

  typedef struct packed {
    logic signed [OUT_MAX-1:0] value;
    logic                      clip;
  } sat_res_t;

  typedef struct packed {
    logic i;
    logic q;
  } iq_pair_t;

  function automatic int acc_width(int w_sig, int w_nco, int n_win);
    return w_sig + w_nco + $clog2(n_win);
  endfunction

  // Arithmetic shift, then clamp into a w_out-bit signed range.
  function automatic sat_res_t sat_shift(logic signed [ACC_MAX-1:0] acc, int shift, int w_out);
    logic signed [ACC_MAX-1:0] shifted;
    logic signed [ACC_MAX-1:0] hi;
    logic signed [ACC_MAX-1:0] lo;
    sat_res_t r;
    shifted = acc >>> shift;
    hi = (ACC_MAX'(1) <<< (w_out - 1)) - ACC_MAX'(1);
    lo = ~hi;
    r.clip = (shifted > hi) || (shifted < lo);
    if (shifted > hi)      r.value = OUT_MAX'(hi);
    else if (shifted < lo) r.value = OUT_MAX'(lo);
    else                   r.value = OUT_MAX'(shifted);
    return r;
  endfunction

endpackage

// File: rtl/iq_integrate_dump_if.sv
// Sample/result bundle of iq_integrate_dump; mag/mag_valid exist only when IQ_MAG_EN is defined.
interface iq_integrate_dump_if #(
  parameter int W_SIG = 32,
  parameter int W_NCO = 32,
  parameter int N_WIN = 16,
  parameter int W_OUT = 32
);
  logic                       enabel;
  logic                       clear;
  logic                       valid_gen;
  logic signed [W_SIG-1:0]    signal;
  logic signed [W_NCO-1:0]    sin;
  logic signed [W_NCO-1:0]    cos;
  logic signed [W_OUT-1:0]    i_out;
  logic signed [W_OUT-1:0]    q_out;
  logic                       valid_out;
  logic                       sat;
  logic [$clog2(N_WIN)-1:0]   win_cnt;
`ifdef IQ_MAG_EN
  logic [W_OUT-1:0]           mag;
  logic                       mag_valid;

  modport master (output enabel, clear, valid_gen, signal, sin, cos,
                  input  i_out, q_out, valid_out, sat, win_cnt, mag, mag_valid);
  modport slave  (input  enabel, clear, valid_gen, signal, sin, cos,
                  output i_out, q_out, valid_out, sat, win_cnt, mag, mag_valid);
`else
  modport master (output enabel, clear, valid_gen, signal, sin, cos,
                  input  i_out, q_out, valid_out, sat, win_cnt);
  modport slave  (input  enabel, clear, valid_gen, signal, sin, cos,
                  output i_out, q_out, valid_out, sat, win_cnt);
`endif
endinterface

// File: rtl/iq_acc_channel.sv
// One correlator lane: product (S2), windowed accumulator (S3), shift/saturate (S4a) and output hold (S4b).
module iq_acc_channel
  import iq_pkg::*;
#(
  parameter int W_SIG = 32,
  parameter int W_NCO = 32,
  parameter int N_WIN = 16,
  parameter int SHIFT = 24,
  parameter int W_OUT = 32
) (
  input  logic                    clk,
  input  logic                    reset_l,
  input  logic                    adv,
  input  logic                    clr,
  input  logic                    acc_en,
  input  logic                    dump,
  input  logic                    ld_res,
  input  logic                    ld_out,
  input  logic signed [W_SIG-1:0] s,
  input  logic signed [W_NCO-1:0] g,
  output logic signed [W_OUT-1:0] y,
  output logic                    clip
);
  localparam int WP = W_SIG + W_NCO;
  localparam int WA = acc_width(W_SIG, W_NCO, N_WIN);

  logic signed [WP-1:0]    prod_q, prod_d;
  logic signed [WA-1:0]    acc_q, acc_d, dump_q, dump_d, sum;
  logic signed [W_OUT-1:0] res_q, res_d, y_q, y_d;
  logic                    clip_q, clip_d, fits;
  sat_res_t                sr;

  always_comb begin
    sum    = acc_q + WA'(prod_q);
    sr     = sat_shift(ACC_MAX'(dump_q), SHIFT, W_OUT);
    // Saturated value always sign-fills the upper bits; fold them in as a guard.
    fits   = (sr.value[OUT_MAX-1:W_OUT-1] == {(OUT_MAX-W_OUT+1){sr.value[W_OUT-1]}});
    prod_d = adv ? WP'(s) * WP'(g) : prod_q;
    acc_d  = acc_q;
    dump_d = dump_q;
    res_d  = res_q;
    clip_d = clip_q;
    y_d    = y_q;
    if (clr) begin
      acc_d = '0;
    end else if (dump) begin
      dump_d = sum;
      acc_d  = '0;
    end else if (acc_en) begin
      acc_d = sum;
    end
    if (ld_res) begin
      res_d  = sr.value[W_OUT-1:0];
      clip_d = sr.clip | ~fits;
    end
    if (ld_out) y_d = res_q;
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      prod_q <= '0;
      acc_q  <= '0;
      dump_q <= '0;
      res_q  <= '0;
      clip_q <= 1'b0;
      y_q    <= '0;
    end else begin
      prod_q <= prod_d;
      acc_q  <= acc_d;
      dump_q <= dump_d;
      res_q  <= res_d;
      clip_q <= clip_d;
      y_q    <= y_d;
    end
  end

  assign y    = y_q;
  assign clip = clip_q;
endmodule

// File: rtl/iq_integrate_dump.sv
// Quadrature integrate-and-dump correlator: S1 capture, two lanes, window counter and valid pipeline.
// Optional IQ_MAG_EN adds an alpha-max/beta-min magnitude output one cycle after each dump.
module iq_integrate_dump
  import iq_pkg::*;
#(
  parameter int W_SIG = 32,
  parameter int W_NCO = 32,
  parameter int N_WIN = 16,
  parameter int SHIFT = 24,
  parameter int W_OUT = 32
) (
  input logic                clk,
  input logic                reset_l,
  iq_integrate_dump_if.slave bus
);
  localparam int             WC   = $clog2(N_WIN);
  localparam logic [WC-1:0]  LAST = WC'(N_WIN - 1);

  logic signed [W_SIG-1:0] sig_q, sig_d;
  logic signed [W_NCO-1:0] sin_q, sin_d, cos_q, cos_d;
  logic                    v1_q, v1_d, v2_q, v2_d, dv3_q, dv3_d, dv4_q, dv4_d;
  logic                    valid_out_q, valid_out_d, sat_q, sat_d;
  logic [WC-1:0]           cnt_q, cnt_d;
  logic                    adv, acc_en, dump, ld_res, ld_out;
  logic signed [W_OUT-1:0] i_y, q_y;
  logic                    clip_i, clip_q;
  iq_pair_t                clip_pair;

  assign clip_pair = '{i: clip_i, q: clip_q};

  always_comb begin
    adv    = bus.enabel & ~bus.clear;
    acc_en = adv & v2_q;
    dump   = acc_en & (cnt_q == LAST);
    ld_res = adv & dv3_q;
    ld_out = adv & dv4_q;
    sig_d  = adv ? bus.signal : sig_q;
    sin_d  = adv ? bus.sin : sin_q;
    cos_d  = adv ? bus.cos : cos_q;
    v1_d   = v1_q;
    v2_d   = v2_q;
    dv3_d  = dv3_q;
    dv4_d  = dv4_q;
    cnt_d  = cnt_q;
    sat_d  = sat_q;
    valid_out_d = 1'b0;
    if (bus.clear) begin
      v1_d  = 1'b0;
      v2_d  = 1'b0;
      dv3_d = 1'b0;
      dv4_d = 1'b0;
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (bus.enabel) begin
      v1_d        = bus.valid_gen;
      v2_d        = v1_q;
      dv3_d       = dump;
      dv4_d       = dv3_q;
      valid_out_d = dv4_q;
      if (v2_q) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      if (ld_out && (|clip_pair)) sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      sig_q       <= '0;
      sin_q       <= '0;
      cos_q       <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      dv3_q       <= 1'b0;
      dv4_q       <= 1'b0;
      valid_out_q <= 1'b0;
      sat_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sig_q       <= sig_d;
      sin_q       <= sin_d;
      cos_q       <= cos_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      dv3_q       <= dv3_d;
      dv4_q       <= dv4_d;
      valid_out_q <= valid_out_d;
      sat_q       <= sat_d;
      cnt_q       <= cnt_d;
    end
  end

  iq_acc_channel #(.W_SIG(W_SIG), .W_NCO(W_NCO), .N_WIN(N_WIN), .SHIFT(SHIFT), .W_OUT(W_OUT)) u_i (
    .clk(clk), .reset_l(reset_l), .adv(adv), .clr(bus.clear), .acc_en(acc_en), .dump(dump),
    .ld_res(ld_res), .ld_out(ld_out), .s(sig_q), .g(cos_q), .y(i_y), .clip(clip_i)
  );

  iq_acc_channel #(.W_SIG(W_SIG), .W_NCO(W_NCO), .N_WIN(N_WIN), .SHIFT(SHIFT), .W_OUT(W_OUT)) u_q (
    .clk(clk), .reset_l(reset_l), .adv(adv), .clr(bus.clear), .acc_en(acc_en), .dump(dump),
    .ld_res(ld_res), .ld_out(ld_out), .s(sig_q), .g(sin_q), .y(q_y), .clip(clip_q)
  );

  assign bus.i_out     = i_y;
  assign bus.q_out     = q_y;
  assign bus.valid_out = valid_out_q;
  assign bus.sat       = sat_q;
  assign bus.win_cnt   = cnt_q;

`ifdef IQ_MAG_EN
  localparam logic [W_OUT-1:0] POS_MAX = {1'b0, {(W_OUT-1){1'b1}}};

  logic [W_OUT-1:0] mag_q, mag_d, abs_i, abs_q, mx, mn;
  logic [W_OUT:0]   msum;
  logic             mag_valid_q, mag_valid_d;

  // The most negative code has no positive twin, so it clamps to POS_MAX.
  function automatic logic [W_OUT-1:0] sat_abs(logic signed [W_OUT-1:0] x);
    logic [W_OUT-1:0] neg;
    neg = ~x + 1'b1;
    if (!x[W_OUT-1]) return x;
    return neg[W_OUT-1] ? POS_MAX : neg;
  endfunction

  always_comb begin
    abs_i       = sat_abs(i_y);
    abs_q       = sat_abs(q_y);
    mx          = (abs_i > abs_q) ? abs_i : abs_q;
    mn          = (abs_i > abs_q) ? abs_q : abs_i;
    msum        = {1'b0, mx} + (W_OUT+1)'(mn >> 1);
    mag_valid_d = valid_out_q;
    mag_d       = mag_q;
    if (valid_out_q) mag_d = (msum > {1'b0, POS_MAX}) ? POS_MAX : msum[W_OUT-1:0];
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      mag_q       <= '0;
      mag_valid_q <= 1'b0;
    end else begin
      mag_q       <= mag_d;
      mag_valid_q <= mag_valid_d;
    end
  end

  assign bus.mag       = mag_q;
  assign bus.mag_valid = mag_valid_q;
`endif
endmodule

// File: doc/iq_integrate_dump.md
Name: iq_integrate_dump

Overview:
- Quadrature correlator that sits directly downstream of the NCO/FLL generator stage.
- Mixes the sampled input `signal` with the generator's `sin`/`cos` outputs (I = signal·cos, Q = signal·sin).
- Integrates products over a window of N_WIN accepted samples, then dumps saturated, scaled I/Q words with a one-cycle valid strobe.
- Feeds the downstream symbol decision / decoder logic.

Parameters:
- W_SIG, 32, width of signed input `signal`.
- W_NCO, 32, width of signed `sin`/`cos` from generator.
- N_WIN, 16, samples per integration window (≥2).
- SHIFT, 24, arithmetic right shift applied to accumulator before output saturation.
- W_OUT, 32, width of signed I/Q outputs.

Ports:
- clk  in  1  system clock
- reset_l  in  1  asynchronous active-low reset
- enabel  in  1  block enable; low freezes all pipeline stages and counter
- clear  in  1  synchronous window restart; zeroes accumulators, counter and in-flight valids
- signal  in  W_SIG  signed input sample
- sin  in  W_NCO  signed generator sine
- cos  in  W_NCO  signed generator cosine
- valid_gen  in  1  generator sample strobe; a sample is accepted when valid_gen && enabel
- i_out  out  W_OUT  signed integrated in-phase result
- q_out  out  W_OUT  signed integrated quadrature result
- valid_out  out  1  one-cycle strobe, i_out/q_out updated
- sat  out  1  sticky; set if any dump saturated, cleared by clear or reset
- win_cnt  out  $clog2(N_WIN)  samples accepted in current window

Behaviour:
- Reset: clk, asynchronous active-low reset_l. All registers, including i_out, q_out, valid_out, sat and win_cnt, go to 0 immediately while reset_l=0.
- Pipeline stages, advancing only when enabel=1:
  - S1: register signal/sin/cos and v1 = valid_gen.
  - S2: signed products P_I = s·cos, P_Q = s·sin, each W_SIG+W_NCO bits; v2 = v1.
  - S3: accumulate. Accumulator width WA = W_SIG+W_NCO+$clog2(N_WIN); products are sign-extended, with no wrap inside the window.
- Window counter (counts v2 in S3):
  - cnt = 0..N_WIN-1.
  - On v2 with cnt == N_WIN-1: dump acc+P, reload acc with 0, cnt←0.
  - Otherwise on v2: acc += P, cnt++.
  - No sample is lost across window boundaries.
- Output stage S4:
  - Dumped value is arithmetically shifted right by SHIFT, then saturated to [-2^(W_OUT-1), 2^(W_OUT-1)-1].
  - valid_out=1 for exactly one cycle.
  - If either channel clips, sat←1.
  - i_out/q_out hold their value between dumps.
- Latency: valid_out asserts 4 enabled clk edges after the edge accepting the N_WIN-th sample.
- enabel=0:
  - No stage advances and valid_out is forced 0.
  - On re-enable, processing continues with no lost or duplicated samples.
- clear=1 (higher priority than enabel):
  - acc, cnt, v1, v2 ← 0; sat ← 0; valid_out ← 0.
  - i_out/q_out hold their value.
  - The sample presented in the clear cycle is discarded.
- valid_gen is sampled every cycle; back-to-back strobes are accepted at full rate, with no backpressure.
- Reset mid-window discards the partial window; the first window after reset starts at cnt=0.

Optional Feature:
- Macro IQ_MAG_EN.
- When defined:
  - Adds output `mag` (W_OUT, unsigned range) = max(|I|,|Q|) + (min(|I|,|Q|) >> 1), computed from saturated i_out/q_out.
  - Adds output `mag_valid`, a one-cycle strobe exactly 1 clk after valid_out.
  - |−2^(W_OUT-1)| is clamped to 2^(W_OUT-1)-1, and the sum saturates at 2^(W_OUT-1)-1.
  - Both outputs reset to 0.
- When undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package iq_pkg:
  - function sat_shift(acc, SHIFT, W_OUT) returning value and clip flag.
  - localparam helper for WA.
  - typedef iq_pair_t {i, q}.
- Sub-module iq_acc_channel: one S2–S4 lane (product, accumulator, shift/saturate) instantiated twice (I and Q); the counter and valid pipeline stay in the top.

Test Plan:
- Constant fill: N_WIN=4, SHIFT=0, signal=1000, cos=2, sin=-3, valid_gen every cycle → valid_out every 4th cycle, i_out=8000, q_out=-12000, first strobe 4 cycles after 4th accept.
- Gapped input: same stimulus with valid_gen every 3rd cycle and enabel toggling low for 5 cycles mid-window → identical results, one strobe per 4 accepted samples.
- Saturation: W_OUT=16, SHIFT=0, signal=30000, cos=30000 → i_out=32767, sat=1 sticky; repeat with cos=-30000 → i_out=-32768.
- Clear mid-window: clear pulsed after 2 samples → next dump covers exactly the 4 samples after clear; sat=0.
- Async reset: reset_l low mid-window without a clock edge → outputs 0 immediately; after release, first window starts at win_cnt=0.
- IQ_MAG_EN: i_out=3000, q_out=-4000 → mag=5500 with mag_valid 1 cycle after valid_out.
